// File: rtl/bp_perf_monitor_pkg.sv
// Shared types and constants for the branch-prediction performance monitor.
package bp_perf_pkg;

    // Monitor operating states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        DUMP = 2'd3
    } bp_perf_state_e;

    // Counter / stream word index.
    typedef enum logic [1:0] {
        CYCLES   = 2'd0,
        INSTRS   = 2'd1,
        BRANCHES = 2'd2,
        MISSES   = 2'd3
    } bp_perf_idx_e;

    localparam int NUM_CNT = 4;

    localparam logic [31:0] DEFAULT_NOP_INSN  = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_HALT_INSN = 32'h0000_0073;

    // A fetched word counts as an instruction unless it is the canonical
    // NOP or an all-zero bubble.
    function automatic logic is_counted_insn(logic [31:0] insn, logic [31:0] nop);
        return (insn != nop) && (insn != 32'h0);
    endfunction

endpackage

// File: rtl/bp_perf_monitor_if.sv
// Valid/ready stream carrying counter snapshot words out of the monitor.
interface bp_perf_monitor_if #(
    parameter int unsigned CNT_W = 32
);
    logic [CNT_W-1:0] data;
    logic [1:0]       idx;
    logic             vld;
    logic             last;
    logic             rdy;

    modport master (
        output data,
        output idx,
        output vld,
        output last,
        input  rdy
    );

    modport slave (
        input  data,
        input  idx,
        input  vld,
        input  last,
        output rdy
    );
endinterface

// File: rtl/bp_perf_monitor_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_reg;

    // Clear has priority over increment; a full counter ignores increments.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            cnt_reg <= '0;
        end else if (inc_i && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/bp_perf_monitor.sv
// Branch-prediction performance monitor: counts cycles, instructions,
// branches and mispredicts while the core runs, and streams a snapshot of
// the four counters on request.
module bp_perf_monitor
    import bp_perf_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter logic [31:0] HALT_INSN = DEFAULT_HALT_INSN,
    parameter logic [31:0] NOP_INSN  = DEFAULT_NOP_INSN
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              br_miss_i,
    input  logic              br_instr_i,
    input  logic [31:0]       instr_i,
    input  logic              dump_req_i,
    bp_perf_monitor_if.master stream,
    output logic              halted_o,
    output logic              busy_o
);

    bp_perf_state_e   state_reg;
    bp_perf_state_e   ret_reg;

    logic             counting;
    logic             clr_live;
    logic             halt_seen;
    logic             dump_start;
    logic             handshake;
    logic [NUM_CNT-1:0] inc;

    logic [CNT_W-1:0] cnt        [NUM_CNT];
    logic [CNT_W-1:0] cnt_next   [NUM_CNT];
    logic [CNT_W-1:0] shadow_reg [NUM_CNT];

    logic [CNT_W-1:0] data_reg;
    logic [1:0]       idx_reg;
    logic             vld_reg;
    logic             last_reg;
    logic             busy_reg;
    logic             halted_reg;

    // Decode this cycle's counter increments and control events. Counting
    // continues through a dump only when the dump was taken from RUN and no
    // halt has been seen since.
    always_comb begin
        counting   = (state_reg == RUN) || ((state_reg == DUMP) && (ret_reg == RUN));
        clr_live   = clr_i && (state_reg != DUMP);
        halt_seen  = counting && (instr_i == HALT_INSN);
        dump_start = dump_req_i && !clr_i && ((state_reg == RUN) || (state_reg == HALT));
        handshake  = vld_reg && stream.rdy;

        inc           = '0;
        inc[CYCLES]   = counting;
        inc[INSTRS]   = counting && is_counted_insn(instr_i, NOP_INSN);
        inc[BRANCHES] = counting && br_instr_i;
        inc[MISSES]   = counting && br_miss_i;
    end

    // One saturating counter per event; cnt_next is the value the counter
    // takes at the coming edge so a snapshot includes the request cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .clr_i  (clr_live),
                .inc_i  (inc[gi]),
                .cnt_o  (cnt[gi])
            );

            assign cnt_next[gi] = (inc[gi] && (cnt[gi] != {CNT_W{1'b1}}))
                                ? cnt[gi] + CNT_W'(1) : cnt[gi];
        end
    endgenerate

    // Control FSM with registered stream outputs, shadow capture and halt flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            ret_reg    <= RUN;
            data_reg   <= '0;
            idx_reg    <= 2'd0;
            vld_reg    <= 1'b0;
            last_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            halted_reg <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow_reg[i] <= '0;
            end
        end else begin
            if (clr_live) begin
                halted_reg <= 1'b0;
            end else if (halt_seen) begin
                halted_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (en_i) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // A clear restarts the counts but keeps the run going.
                    if (!clr_i && halt_seen) begin
                        state_reg <= HALT;
                    end
                end
                HALT: begin
                    if (clr_i) begin
                        state_reg <= IDLE;
                    end
                end
                DUMP: begin
                    if (halt_seen) begin
                        ret_reg <= HALT;
                    end
                    if (handshake) begin
                        if (last_reg) begin
                            vld_reg   <= 1'b0;
                            last_reg  <= 1'b0;
                            busy_reg  <= 1'b0;
                            idx_reg   <= 2'd0;
                            state_reg <= halt_seen ? HALT : ret_reg;
                        end else begin
                            idx_reg  <= idx_reg + 2'd1;
                            data_reg <= shadow_reg[idx_reg + 2'd1];
                            last_reg <= (idx_reg == 2'd2);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Snapshot request overrides the RUN/HALT transitions above;
            // a halt in the request cycle makes HALT the return state.
            if (dump_start) begin
                state_reg <= DUMP;
                ret_reg   <= ((state_reg == HALT) || halt_seen) ? HALT : RUN;
                busy_reg  <= 1'b1;
                vld_reg   <= 1'b1;
                last_reg  <= 1'b0;
                idx_reg   <= 2'd0;
                data_reg  <= cnt_next[CYCLES];
                for (int i = 0; i < NUM_CNT; i++) begin
                    shadow_reg[i] <= cnt_next[i];
                end
            end
        end
    end

    assign stream.data = data_reg;
    assign stream.idx  = idx_reg;
    assign stream.vld  = vld_reg;
    assign stream.last = last_reg;
    assign halted_o    = halted_reg;
    assign busy_o      = busy_reg;

endmodule

// File: tb/tb_bp_perf_monitor.sv
// Self-checking bench for bp_perf_monitor: a 32-bit and a 4-bit instance
// share all stimulus and are compared against a queue-based reference model.
module tb_bp_perf_monitor;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HLT  = 32'h0000_0073;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int M_DUMP = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        br_miss;
    logic        br_instr;
    logic [31:0] instr;
    logic        dump_req;
    logic        rdy;
    logic        halted;
    logic        busy;
    logic        halted4;
    logic        busy4;

    bp_perf_monitor_if #(.CNT_W(32)) s  ();
    bp_perf_monitor_if #(.CNT_W(4))  s4 ();

    assign s.rdy  = rdy;
    assign s4.rdy = rdy;

    bp_perf_monitor #(.CNT_W(32)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .clr_i      (clr),
        .br_miss_i  (br_miss),
        .br_instr_i (br_instr),
        .instr_i    (instr),
        .dump_req_i (dump_req),
        .stream     (s),
        .halted_o   (halted),
        .busy_o     (busy)
    );

    bp_perf_monitor #(.CNT_W(4)) dut4 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .clr_i      (clr),
        .br_miss_i  (br_miss),
        .br_instr_i (br_instr),
        .instr_i    (instr),
        .dump_req_i (dump_req),
        .stream     (s4),
        .halted_o   (halted4),
        .busy_o     (busy4)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: raw (unbounded) event totals, saturation applied on
    // comparison; pending stream words kept as a queue.
    int              m_st     = M_IDLE;
    int              m_ret    = M_RUN;
    bit              m_halted = 1'b0;
    longint unsigned m_cnt [4];
    longint unsigned exp_q [$];

    logic [31:0] got32 [$];
    logic [3:0]  got4  [$];

    function automatic logic [63:0] sat(longint unsigned v, int w);
        logic [63:0] mx;
        mx = (64'd1 << w) - 64'd1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [31:0] rand_word_nz();
        return $urandom | 32'h8000_0000;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return NOP;
            1:       return 32'h0;
            default: return rand_word_nz();
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one cycle using the inputs currently applied.
    task automatic model_step();
        bit counting;
        bit clr_eff;
        bit halt;
        bit hs_last;
        if (!rst_n) begin
            m_st = M_IDLE;
            m_ret = M_RUN;
            m_halted = 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            exp_q.delete();
            return;
        end
        counting = (m_st == M_RUN) || (m_st == M_DUMP && m_ret == M_RUN);
        clr_eff  = clr && (m_st != M_DUMP);
        halt     = counting && (instr == HLT);
        hs_last  = 1'b0;
        if (m_st == M_DUMP && rdy) begin
            void'(exp_q.pop_front());
            hs_last = (exp_q.size() == 0);
        end
        if (clr_eff) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (counting) begin
            m_cnt[0]++;
            if (instr != NOP && instr != 32'h0) m_cnt[1]++;
            if (br_instr) m_cnt[2]++;
            if (br_miss)  m_cnt[3]++;
        end
        case (m_st)
            M_IDLE: if (en) m_st = M_RUN;
            M_RUN: begin
                if (clr) begin
                end else if (dump_req) begin
                    for (int i = 0; i < 4; i++) exp_q.push_back(m_cnt[i]);
                    m_ret = halt ? M_HALT : M_RUN;
                    m_st  = M_DUMP;
                end else if (halt) begin
                    m_st = M_HALT;
                end
            end
            M_HALT: begin
                if (clr) begin
                    m_st = M_IDLE;
                end else if (dump_req) begin
                    for (int i = 0; i < 4; i++) exp_q.push_back(m_cnt[i]);
                    m_ret = M_HALT;
                    m_st  = M_DUMP;
                end
            end
            default: begin
                if (halt) m_ret = M_HALT;
                if (hs_last) m_st = m_ret;
            end
        endcase
        if (clr_eff) m_halted = 1'b0;
        else if (halt) m_halted = 1'b1;
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (exp_q.size() != 0);
        check("halted",   halted,  m_halted);
        check("halted4",  halted4, m_halted);
        check("busy",     busy,    m_st == M_DUMP);
        check("busy4",    busy4,   m_st == M_DUMP);
        check("vld",      s.vld,   ev);
        check("vld4",     s4.vld,  ev);
        if (ev) begin
            check("idx",   s.idx,   4 - exp_q.size());
            check("idx4",  s4.idx,  4 - exp_q.size());
            check("last",  s.last,  exp_q.size() == 1);
            check("data",  s.data,  sat(exp_q[0], 32));
            check("data4", s4.data, sat(exp_q[0], 4));
        end
    endtask

    // One clock: record accepted words, step the model, check after the edge.
    task automatic tick();
        if (s.vld && rdy) begin
            got32.push_back(s.data);
            got4.push_back(s4.data);
        end
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        en = 1'b0; clr = 1'b0; br_miss = 1'b0; br_instr = 1'b0;
        instr = NOP; dump_req = 1'b0;
    endtask

    task automatic run_cycles(int n);
        for (int i = 0; i < n; i++) begin
            instr    = rand_word();
            br_instr = 1'($urandom_range(0, 1));
            br_miss  = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
    endtask

    // mode 0: rdy high, 1: rdy toggles 0/1, 2: random rdy.
    // exp_len < 0 skips the stream-length check.
    task automatic dump_and_drain(int mode, bit live_miss, int halt_at, int exp_len);
        int n;
        int k;
        got32.delete();
        got4.delete();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        br_instr = 1'b0;
        n = busy ? 1 : 0;
        k = 0;
        while (busy && k < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'(k % 2);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            br_miss = live_miss;
            instr   = (k == halt_at) ? HLT : rand_word();
            tick();
            if (busy) n++;
            k++;
        end
        idle_inputs();
        rdy = 1'b1;
        check("drain_timeout", busy, 1'b0);
        if (exp_len >= 0) check("stream_len", n, exp_len);
        check("words_got", got32.size(), 4);
    endtask

    task automatic check_words(string tag, int w0, int w1, int w2, int w3);
        int ew [4];
        ew = '{w0, w1, w2, w3};
        for (int i = 0; i < 4 && i < got32.size(); i++) begin
            check(tag, got32[i], ew[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rdy   = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_data", s.data, 0);
        check("rst_idx",  s.idx,  0);
        check("rst_last", s.last, 0);

        // Directed count: 10 run cycles plus the halt cycle.
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            instr    = (i < 6) ? rand_word_nz() : ((i % 2) ? 32'h0 : NOP);
            br_instr = (i == 1 || i == 4 || i == 7);
            br_miss  = (i == 4);
            tick();
        end
        idle_inputs();
        instr = HLT;
        tick();
        instr = NOP;
        tick();
        check("halted_after_halt", halted, 1'b1);
        dump_and_drain(0, 1'b0, -1, 4);
        check_words("count_words", 11, 7, 3, 1);

        // Backpressure: rdy toggles, words must not skip or repeat.
        dump_and_drain(1, 1'b0, -1, 8);
        check_words("bp_words", 11, 7, 3, 1);

        // Clear beats a simultaneous dump request; IDLE ignores requests.
        clr = 1'b1;
        dump_req = 1'b1;
        tick();
        idle_inputs();
        check("clr_no_vld", s.vld, 1'b0);
        check("clr_halted", halted, 1'b0);
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("idle_dump_ignored", busy, 1'b0);
        tick();

        // Dump while running, miss in the request cycle, halt during dump.
        en = 1'b1;
        tick();
        en = 1'b0;
        run_cycles(12);
        br_miss  = 1'b1;
        br_instr = 1'($urandom_range(0, 1));
        instr    = rand_word();
        dump_and_drain(2, 1'b1, 2, -1);
        check("halt_in_dump", halted, 1'b1);
        tick();
        dump_and_drain(0, 1'b0, -1, 4);

        // Saturation of the 4-bit instance.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en = 1'b1;
        tick();
        en = 1'b0;
        run_cycles(20);
        instr = HLT;
        tick();
        instr = NOP;
        dump_and_drain(0, 1'b0, -1, 4);
        if (got4.size() > 0) check("sat_cycles4", got4[0], 15);
        check_words("sat_words32", 21, int'(m_cnt[1]), int'(m_cnt[2]), int'(m_cnt[3]));

        // Reset in the middle of a dump, after idx 1 has been accepted.
        got32.delete();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        rdy = 1'b1;
        tick();
        tick();
        rdy = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rdy = 1'b1;
        check("rst_mid_vld",    s.vld,  1'b0);
        check("rst_mid_busy",   busy,   1'b0);
        check("rst_mid_halted", halted, 1'b0);
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("rst_idle_dump_ignored", busy, 1'b0);
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            instr = rand_word_nz();
            tick();
        end
        instr = HLT;
        tick();
        instr = NOP;
        dump_and_drain(0, 1'b0, -1, 4);
        check_words("rerun_words", 6, 6, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
